// File: rtl/clint_bus_arbiter.sv
// clint_bus_arbiter
//   Shares one CLINT register port between N_REQ requesters. Each requester
//   owns a one-entry buffer. Pending buffers are granted round-robin, and the
//   owner's transaction is driven to the CLINT side until s_ready arrives or
//   TIMEOUT BUSY cycles pass. The result is returned to that requester as a
//   one-cycle m_ready pulse.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   m_valid         per-requester one-cycle request pulse
//   m_address       packed requester addresses, requester i at [i*ADDR_W +: ADDR_W]
//   m_wdata         packed write data, same packing
//   m_wstrb         packed byte strobes (all-zero = read)
//   m_rdata         response data, shared, non-zero only in RESP
//   m_ready         per-requester one-cycle completion pulse
//   s_valid/s_address/s_wdata/s_wstrb   CLINT-side request, non-zero only in BUSY
//   s_rdata, s_ready                    CLINT-side response
//   grant           one-hot owner during BUSY/RESP, zero in IDLE
//   timeout_err     set together with m_ready when the response timed out
//   dbg_state       current FSM state (0 IDLE, 1 BUSY, 2 RESP)
//
// Handshake: a request is a single-cycle m_valid pulse. The request is
// accepted when the requester's buffer is empty, or during its own RESP
// cycle; otherwise it is dropped. s_valid is held with stable fields
// throughout BUSY, and the CLINT completes the transfer by raising s_ready
// in any BUSY cycle. s_ready is ignored in every other state. m_ready is a
// single-cycle pulse that the requester cannot stall.
module clint_bus_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             m_valid,
  input  logic [N_REQ*ADDR_W-1:0]      m_address,
  input  logic [N_REQ*DATA_W-1:0]      m_wdata,
  input  logic [N_REQ*(DATA_W/8)-1:0]  m_wstrb,
  output logic [DATA_W-1:0]            m_rdata,
  output logic [N_REQ-1:0]             m_ready,
  output logic                         s_valid,
  output logic [ADDR_W-1:0]            s_address,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_wstrb,
  input  logic [DATA_W-1:0]            s_rdata,
  input  logic                         s_ready,
  output logic [N_REQ-1:0]             grant,
  output logic                         timeout_err,
  output logic [1:0]                   dbg_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(N_REQ);
  localparam int CNT_W  = $clog2(TIMEOUT);

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [N_REQ-1:0]  pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q  [N_REQ];
  logic [ADDR_W-1:0] addr_d  [N_REQ];
  logic [DATA_W-1:0] wdata_q [N_REQ];
  logic [DATA_W-1:0] wdata_d [N_REQ];
  logic [STRB_W-1:0] wstrb_q [N_REQ];
  logic [STRB_W-1:0] wstrb_d [N_REQ];
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic              own_resp;
  logic              busy, resp;

  // Round-robin pick: first pending index starting just after the last owner.
  always_comb begin
    int j;
    sel_found = 1'b0;
    sel_idx   = '0;
    j         = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = int'(last_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!sel_found && pend_q[j[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = j[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    own_resp = 1'b0;

    // Buffer capture. The owner may reload in its own RESP cycle, so the
    // clear on completion is overridden by a fresh request in that cycle.
    for (int i = 0; i < N_REQ; i++) begin
      own_resp = (state_q == ST_RESP) && (owner_q == IDX_W'(i));
      if (own_resp) pend_d[i] = 1'b0;
      if (m_valid[i] && (!pend_q[i] || own_resp)) begin
        pend_d[i]  = 1'b1;
        addr_d[i]  = m_address[i*ADDR_W +: ADDR_W];
        wdata_d[i] = m_wdata[i*DATA_W +: DATA_W];
        wstrb_d[i] = m_wstrb[i*STRB_W +: STRB_W];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          owner_d = sel_idx;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (s_ready) begin
          rdata_d = s_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_MAX) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      owner_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        wstrb_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      for (int i = 0; i < N_REQ; i++) begin
        addr_q[i]  <= addr_d[i];
        wdata_q[i] <= wdata_d[i];
        wstrb_q[i] <= wstrb_d[i];
      end
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign resp = (state_q == ST_RESP);

  always_comb begin
    s_valid     = busy;
    s_address   = busy ? addr_q[owner_q]  : '0;
    s_wdata     = busy ? wdata_q[owner_q] : '0;
    s_wstrb     = busy ? wstrb_q[owner_q] : '0;
    m_rdata     = resp ? rdata_q : '0;
    timeout_err = resp && err_q;
    m_ready     = '0;
    grant       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      m_ready[i] = resp && (owner_q == IDX_W'(i));
      grant[i]   = (busy || resp) && (owner_q == IDX_W'(i));
    end
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_clint_bus_arbiter.sv
module tb_clint_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [N-1:0]      m_valid;
  logic [N*AW-1:0]   m_address;
  logic [N*DW-1:0]   m_wdata;
  logic [N*SW-1:0]   m_wstrb;
  logic [DW-1:0]     m_rdata;
  logic [N-1:0]      m_ready;
  logic              s_valid;
  logic [AW-1:0]     s_address;
  logic [DW-1:0]     s_wdata;
  logic [SW-1:0]     s_wstrb;
  logic [DW-1:0]     s_rdata;
  logic              s_ready;
  logic [N-1:0]      grant;
  logic              timeout_err;
  logic [1:0]        dbg_state;

  clint_bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .s_valid(s_valid), .s_address(s_address), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .grant(grant), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  // ---------------- reference model ----------------
  // Transaction view: each requester holds at most one buffered request.
  // md_owner < 0 means no transaction in flight; otherwise the owner's
  // request is on the bus (md_done=0) or being answered (md_done=1).
  bit            md_pend  [N];
  logic [AW-1:0] md_addr  [N];
  logic [DW-1:0] md_wdata [N];
  logic [SW-1:0] md_wstrb [N];
  int            md_owner;
  int            md_last;
  int            md_waited;
  bit            md_done;
  logic [DW-1:0] md_data;
  bit            md_err;
  bit            take [N];

  task automatic model_step();
    int j;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        md_pend[i] = 0; md_addr[i] = '0; md_wdata[i] = '0; md_wstrb[i] = '0;
      end
      md_owner = -1; md_last = N - 1; md_waited = 0; md_done = 0;
      md_data = '0; md_err = 0;
      return;
    end
    for (int i = 0; i < N; i++)
      take[i] = m_valid[i] && (!md_pend[i] || (md_owner == i && md_done));
    if (md_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        j = (md_last + k) % N;
        if (md_owner < 0 && md_pend[j]) md_owner = j;
      end
      md_waited = 0;
    end else if (!md_done) begin
      if (s_ready) begin
        md_data = s_rdata; md_err = 0; md_done = 1;
      end else if (md_waited == TO - 1) begin
        md_data = '0; md_err = 1; md_done = 1;
      end else begin
        md_waited++;
      end
    end else begin
      md_pend[md_owner] = 0;
      md_last  = md_owner;
      md_owner = -1;
      md_done  = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (take[i]) begin
        md_pend[i]  = 1;
        md_addr[i]  = m_address[i*AW +: AW];
        md_wdata[i] = m_wdata[i*DW +: DW];
        md_wstrb[i] = m_wstrb[i*SW +: SW];
      end
    end
  endtask

  task automatic compare_all();
    bit            on_bus, answering;
    logic [N-1:0]  onehot;
    on_bus    = (md_owner >= 0) && !md_done;
    answering = (md_owner >= 0) && md_done;
    onehot    = (md_owner >= 0) ? N'(1 << md_owner) : '0;
    chk("s_valid",     s_valid,     on_bus);
    chk("s_address",   s_address,   on_bus ? md_addr[md_owner]  : '0);
    chk("s_wdata",     s_wdata,     on_bus ? md_wdata[md_owner] : '0);
    chk("s_wstrb",     s_wstrb,     on_bus ? md_wstrb[md_owner] : '0);
    chk("m_ready",     m_ready,     answering ? onehot : '0);
    chk("m_rdata",     m_rdata,     answering ? md_data : '0);
    chk("timeout_err", timeout_err, answering && md_err);
    chk("grant",       grant,       onehot);
  endtask

  // ---------------- driver ----------------
  logic [N-1:0] done_q[$];
  logic [N-1:0] exp_q[$];

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    if (m_ready != '0) done_q.push_back(m_ready);
    m_valid = '0;
    s_ready = 1'b0;
    s_rdata = '0;
  endtask

  task automatic req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [SW-1:0] s);
    m_valid[i]          = 1'b1;
    m_address[i*AW +: AW] = a;
    m_wdata[i*DW +: DW]   = d;
    m_wstrb[i*SW +: SW]   = s;
  endtask

  // Runs until m_ready is seen (left in that cycle), optionally answering
  // every BUSY cycle with s_ready.
  task automatic wait_resp(input int budget, input bit auto_ready, input logic [DW-1:0] rd,
                           output bit got, output int sv, output logic [AW-1:0] first_addr);
    got = 0; sv = 0; first_addr = '0;
    for (int n = 0; n < budget; n++) begin
      if (m_ready != '0) begin
        got = 1;
        break;
      end
      if (s_valid) begin
        if (sv == 0) first_addr = s_address;
        sv++;
        if (auto_ready) begin
          s_ready = 1'b1;
          s_rdata = rd;
        end
      end
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  bit            got;
  int            sv, stray;
  logic [AW-1:0] fa;
  logic [31:0]   r;

  initial begin
    reset = 1'b1; m_valid = '0; m_address = '0; m_wdata = '0; m_wstrb = '0;
    s_rdata = '0; s_ready = 1'b0;
    md_owner = -1; md_last = N - 1; md_done = 0; md_waited = 0;
    tick();
    tick();
    chk("rst_s_valid", s_valid, 1'b0);
    chk("rst_grant",   grant,   '0);
    chk("rst_m_ready", m_ready, '0);
    reset = 1'b0;
    tick();

    // Single read, s_ready one cycle late.
    req(0, 16'h0004, 32'h0, 4'h0);
    tick(); chk("lat_t1_s_valid", s_valid, 1'b0);
    tick(); chk("lat_t2_s_valid", s_valid, 1'b1);
            chk("lat_t2_addr", s_address, 16'h0004);
    tick(); chk("lat_t3_s_valid", s_valid, 1'b1);
    s_ready = 1'b1; s_rdata = 32'h1234;
    tick(); chk("lat_t4_m_ready", m_ready, 2'b01);
            chk("lat_t4_rdata", m_rdata, 32'h1234);
            chk("lat_t4_s_valid", s_valid, 1'b0);
    tick(); chk("lat_t5_m_ready", m_ready, 2'b00);

    // Simultaneous requests, round-robin order twice.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    done_q.delete();
    exp_q.delete();
    for (int rep = 0; rep < 2; rep++) begin
      req(0, 16'h0100, 32'hA0A0_0000, 4'hF);
      req(1, 16'h0200, 32'hB0B0_0000, 4'h3);
      exp_q.push_back(2'b01);
      exp_q.push_back(2'b10);
      tick();
      wait_resp(30, 1, 32'h55, got, sv, fa); chk("rr_first_done", got, 1'b1);
      tick();
      wait_resp(30, 1, 32'h66, got, sv, fa); chk("rr_second_done", got, 1'b1);
      tick();
    end
    chk("rr_count", done_q.size(), exp_q.size());
    while (exp_q.size() > 0 && done_q.size() > 0)
      chk("rr_order", done_q.pop_front(), exp_q.pop_front());

    // Timeout: s_ready never asserted.
    req(0, 16'h0014, 32'h0, 4'h0);
    tick();
    wait_resp(40, 0, '0, got, sv, fa);
    chk("to_done", got, 1'b1);
    chk("to_s_valid_cycles", sv, TO);
    chk("to_m_ready", m_ready, 2'b01);
    chk("to_err", timeout_err, 1'b1);
    chk("to_rdata", m_rdata, 32'h0);
    tick();

    // Second pulse while pending is dropped.
    req(1, 16'h0008, 32'h0, 4'h0);
    tick();
    req(1, 16'h000C, 32'h0, 4'h0);
    tick();
    wait_resp(30, 1, 32'h77, got, sv, fa);
    chk("drop_done", got, 1'b1);
    chk("drop_addr", fa, 16'h0008);
    chk("drop_m_ready", m_ready, 2'b10);
    tick();
    stray = 0;
    for (int n = 0; n < 12; n++) begin
      if (m_ready != '0 || s_valid) stray++;
      tick();
    end
    chk("drop_no_second", stray, 0);

    // Reset during BUSY abandons the transaction.
    req(0, 16'h0018, 32'h0, 4'h0);
    tick(); tick();
    chk("rbusy_in_busy", s_valid, 1'b1);
    reset = 1'b1;
    tick();
    chk("rbusy_s_valid", s_valid, 1'b0);
    chk("rbusy_grant", grant, '0);
    reset = 1'b0;
    stray = 0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (m_ready != '0 || s_valid) stray++;
    end
    chk("rbusy_quiet", stray, 0);

    // Reload in own RESP cycle.
    req(0, 16'h0020, 32'h0, 4'h0);
    tick();
    wait_resp(30, 1, 32'h88, got, sv, fa);
    chk("reload_first", got, 1'b1);
    req(0, 16'h0010, 32'hCAFE, 4'hF);
    tick();
    wait_resp(30, 1, 32'h99, got, sv, fa);
    chk("reload_second", got, 1'b1);
    chk("reload_addr", fa, 16'h0010);
    tick();

    // Randomised traffic, every cycle checked against the model.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          r = $urandom;
          m_valid[i] = 1'b1;
          m_address[i*AW +: AW] = r[AW-1:0];
          m_wdata[i*DW +: DW]   = $urandom;
          r = $urandom;
          m_wstrb[i*SW +: SW]   = r[SW-1:0];
        end
      end
      s_ready = ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;
      tick();
    end
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
